inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Consumer end of the PC-register interface.
- Takes the current fetch address `pc_i` from the PC register and reads the 32-bit instruction byte-by-byte over the 8-bit unified RAM port.
- Queues assembled instructions for the decode stage and drives `pc_back_o`, the next sequential PC or a redirect target, back to the PC register.
- Sits between the PC register, the RAM read port and ID.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- QDEPTH, 2, instruction queue entries (power of two, ≥2).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- pc_i  in  ADDR_W  current fetch PC from the PC register
- pc_back_o  out  ADDR_W  next PC returned to the PC register
- mem_a_o  out  ADDR_W  RAM byte address
- mem_wr_o  out  1  RAM write enable, tied 0
- mem_din_i  in  8  RAM read data, valid one cycle after its address
- inst_valid_o  out  1  queue head valid
- inst_o  out  32  queue head instruction, little-endian
- inst_pc_o  out  ADDR_W  PC of queue head
- inst_ready_i  in  1  ID accepts head when valid&ready
- redirect_i  in  1  branch/jump flush request
- redirect_pc_i  in  ADDR_W  redirect target

Behaviour:
- Reset (rst=1 at edge):
  - FSM→IDLE; queue emptied.
  - pc_back_o=0, mem_a_o=0, mem_wr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0.
  - rst mid-fetch aborts all partial bytes.
- FSM states:
  - IDLE
  - B0: issue pc+0
  - B1: issue pc+1, capture byte0
  - B2: issue pc+2, capture byte1
  - B3: issue pc+3, capture byte2
  - B4: capture byte3, push
- Addresses and byte order:
  - mem_a_o = pc_cur+k, combinational from state; pc_cur is latched.
  - Byte k lands in inst bits [8k+7:8k].
- IDLE → B0 when the queue is not full; pc_cur ← pc_i.
- B0 → B1 → B2 → B3 → B4 unconditionally, one per cycle.
- In B4:
  - Push {inst, pc_cur}.
  - pc_back_o ← pc_cur+4 (modulo 2^ADDR_W; wrap from FFFFFFFC to 0 allowed).
  - Next state: B0 with pc_cur ← pc_cur+4 if the queue is not full after the push (accounting for a same-cycle pop); otherwise IDLE.
- Latency: 5 cycles from B0 entry to inst_valid_o, with an empty queue. Sustained rate: one instruction per 5 cycles.
- No alignment check; any byte address is fetched as-is.
- Queue:
  - Circular buffer of QDEPTH entries with wrapping read/write pointers plus a count.
  - Simultaneous push and pop is legal when full; count is unchanged and the slot is reused.
  - Pop on empty is ignored.
  - The head holds its value while inst_ready_i=0.
- Redirect (redirect_i=1 at edge) has priority over everything except rst:
  - Flush the queue.
  - Discard the in-flight fetch, including a B4 push in the same cycle.
  - pc_back_o ← redirect_pc_i; pc_cur ← redirect_pc_i.
  - FSM → B0 next cycle.
  - inst_valid_o=0 the cycle after the redirect.
  - A same-cycle pop by ID is still counted as consumed.
- Back-to-back redirects: the latest one wins.
- mem_a_o while IDLE holds the last issued address, so the RAM sees no spurious new address.

Decomposition:
- Shared package: FSM state encoding (IF_IDLE, IF_B0..IF_B4), ZeroWord, RstEnable, InstAddrBus/InstBus width macros in the common defines include.
- Natural sub-module: `inst_queue`, the parameterised synchronous FIFO holding {inst, pc}. It provides push, pop, full, empty and flush; flush has priority over push.

Test Plan:
- Reset then pc_i=0, RAM[0..3]=13,05,10,00 → mem_a_o 0,1,2,3 on cycles 1-4.
  - Cycle 6: inst_valid_o=1, inst_o=00100513, inst_pc_o=0, pc_back_o=4.
- ID holds inst_ready_i=0 with QDEPTH=2 → two instructions queued (pc 0, 4).
  - FSM idles and pc_back_o=8.
  - Raise ready for one cycle → head becomes pc 4 and fetch of 8 resumes next cycle.
- Redirect mid-fetch: redirect_i=1, redirect_pc_i=0x100 in B2 → next cycle mem_a_o=0x100, queue empty, pc_back_o=0x100.
  - First valid inst_pc_o=0x100 five cycles later.
- Redirect in B4 coinciding with a pop → the B4 instruction is never visible and the count goes to 0.
- Wrap: pc_i=FFFFFFFC → mem_a_o FFFFFFFC..FFFFFFFF, pc_back_o=00000000.
- Assert rst in B3 with the queue holding 1 entry → next cycle all outputs 0 and FSM IDLE.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_pkg
//
// Shared definitions for the instruction fetch slice: fetch FSM state
// encoding, reset polarity, word widths and small helpers that map a fetch
// state to the byte it is addressing.
//
// Contents:
//   INST_W, INST_ADDR_W  instruction and instruction-address widths
//   ZERO_WORD            all-zero instruction word
//   RST_ENABLE           level of rst that means "in reset"
//   if_state_t           fetch FSM states (IF_IDLE, IF_B0..IF_B4)
//   byte_offset()        byte index issued to RAM in a given state
//   issues_addr()        true in the states that put a new address on RAM
// ---------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam int          INST_W      = 32;
    localparam int          INST_ADDR_W = 32;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
    localparam logic        RST_ENABLE  = 1'b1;

    // IF_B0..IF_B3 issue byte addresses pc+0..pc+3; IF_B4 only captures the
    // last byte and pushes the assembled word.
    typedef enum logic [2:0] {
        IF_IDLE = 3'd0,
        IF_B0   = 3'd1,
        IF_B1   = 3'd2,
        IF_B2   = 3'd3,
        IF_B3   = 3'd4,
        IF_B4   = 3'd5
    } if_state_t;

    function automatic logic [1:0] byte_offset(input if_state_t s);
        logic [1:0] off;
        off = 2'd0;
        case (s)
            IF_B1:   off = 2'd1;
            IF_B2:   off = 2'd2;
            IF_B3:   off = 2'd3;
            default: off = 2'd0;
        endcase
        return off;
    endfunction

    function automatic logic issues_addr(input if_state_t s);
        return (s == IF_B0) || (s == IF_B1) || (s == IF_B2) || (s == IF_B3);
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//
// Small synchronous circular FIFO holding fetched {instruction, pc} pairs
// for the decode stage. Wrapping read/write pointers plus an occupancy
// count; DEPTH must be a power of two so the pointers wrap naturally.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous, active-high reset (empties queue, clears storage)
//   flush      empty the queue; wins over push and pop
//   push       write push_data at the tail (accepted when not full, or when
//              full and a pop happens in the same cycle)
//   push_data  entry to write
//   pop        drop the head entry; ignored when empty
//   head_data  entry at the head, held while not popped
//   full       count == DEPTH
//   empty      count == 0
//   count      current occupancy
// ---------------------------------------------------------------------------
module inst_queue
    import inst_fetch_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] slots [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_pop;
    logic              do_push;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push into a full queue is accepted only when the head leaves in the
    // same cycle, in which case the freed slot is reused and count holds.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = slots[rd_ptr];

    // Pointer, count and storage update; flush discards everything,
    // including any push or pop presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage. Takes the fetch PC from the PC register, reads
// the 32-bit instruction one byte per cycle over the 8-bit RAM port
// (little-endian), queues completed instructions for decode and returns the
// next PC (sequential or redirect target) to the PC register.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            synchronous, active-high reset
//   pc_i           current fetch PC from the PC register
//   pc_back_o      next PC returned to the PC register
//   mem_a_o        RAM byte address
//   mem_wr_o       RAM write enable (always 0, fetch only reads)
//   mem_din_i      RAM read data, valid one cycle after its address
//   inst_valid_o   queue head valid
//   inst_o         queue head instruction
//   inst_pc_o      PC of the queue head
//   inst_ready_i   decode accepts the head when valid & ready
//   redirect_i     branch/jump flush request
//   redirect_pc_i  redirect target
// ---------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [ADDR_W-1:0] pc_back_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic              mem_wr_o,
    input  logic [7:0]        mem_din_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              inst_ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam int Q_W   = INST_W + ADDR_W;

    localparam logic [CNT_W-1:0] LAST_FREE = CNT_W'(QDEPTH - 1);

    if_state_t         state;
    if_state_t         state_next;
    logic [ADDR_W-1:0] pc_cur;
    logic [ADDR_W-1:0] pc_back;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] issue_addr;
    logic [23:0]       inst_buf;

    logic              q_push;
    logic [Q_W-1:0]    q_push_data;
    logic [Q_W-1:0]    q_head;
    logic              q_full;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;
    logic              do_pop;
    logic              can_start;
    logic              room_after_push;

    assign do_pop = inst_ready_i && !q_empty;

    // Starting a fetch needs a free slot; a pop in this cycle frees one.
    assign can_start = !q_full || do_pop;

    // In B4 the queue is never full (B0 was only entered with room and only
    // B4 pushes), so the push always lands. There is room for the next fetch
    // if the head leaves this cycle or at least two slots are free now.
    assign room_after_push = do_pop || (q_count < LAST_FREE);

    assign issue_addr = pc_cur + ADDR_W'(byte_offset(state));

    // Outside B0..B3 the RAM keeps seeing the last address it was given.
    assign mem_a_o   = issues_addr(state) ? issue_addr : last_addr;
    assign mem_wr_o  = 1'b0;
    assign pc_back_o = pc_back;

    // The fourth byte is taken straight from the RAM port in B4 so the word
    // is pushed without an extra cycle.
    assign q_push      = (state == IF_B4) && !redirect_i;
    assign q_push_data = {mem_din_i, inst_buf, pc_cur};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state <= IF_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect restarts the byte sequence from B0 no
    // matter where the FSM was.
    always_comb begin
        state_next = state;
        if (redirect_i) begin
            state_next = IF_B0;
        end else begin
            case (state)
                IF_IDLE: if (can_start) state_next = IF_B0;
                IF_B0:   state_next = IF_B1;
                IF_B1:   state_next = IF_B2;
                IF_B2:   state_next = IF_B3;
                IF_B3:   state_next = IF_B4;
                IF_B4:   state_next = room_after_push ? IF_B0 : IF_IDLE;
                default: state_next = IF_IDLE;
            endcase
        end
    end

    // Datapath registers: fetch PC, returned PC, last RAM address and the
    // partially assembled instruction (bytes 0..2; byte 3 goes straight in).
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc_cur    <= '0;
            pc_back   <= '0;
            last_addr <= '0;
            inst_buf  <= '0;
        end else begin
            if (issues_addr(state)) begin
                last_addr <= issue_addr;
            end
            case (state)
                IF_B1:   inst_buf[7:0]   <= mem_din_i;
                IF_B2:   inst_buf[15:8]  <= mem_din_i;
                IF_B3:   inst_buf[23:16] <= mem_din_i;
                default: inst_buf        <= inst_buf;
            endcase
            if (redirect_i) begin
                pc_cur  <= redirect_pc_i;
                pc_back <= redirect_pc_i;
            end else begin
                case (state)
                    IF_IDLE: begin
                        if (can_start) begin
                            pc_cur <= pc_i;
                        end
                    end
                    IF_B4: begin
                        pc_back <= pc_cur + ADDR_W'(4);
                        if (room_after_push) begin
                            pc_cur <= pc_cur + ADDR_W'(4);
                        end
                    end
                    default: pc_cur <= pc_cur;
                endcase
            end
        end
    end

    inst_queue #(
        .DATA_W (Q_W),
        .DEPTH  (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (inst_ready_i),
        .head_data (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign inst_valid_o = !q_empty;
    assign inst_o       = q_head[Q_W-1:ADDR_W];
    assign inst_pc_o    = q_head[ADDR_W-1:0];

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Directed bench for inst_fetch. A byte RAM model answers one cycle after
// each address; a PC-register model feeds pc_back_o back to pc_i unless the
// bench forces a start PC. Expected {instruction, pc} pairs are queued when
// a fetch is set up and compared when the DUT presents them at its head.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i;
    logic [31:0] pc_back_o;
    logic [31:0] mem_a_o;
    logic        mem_wr_o;
    logic [7:0]  mem_din_i = 8'h00;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;

    logic        pc_force_en = 1'b1;
    logic [31:0] pc_force = 32'h0;

    int total = 0;
    int bad   = 0;

    logic [63:0] sb [$];

    inst_fetch #(
        .ADDR_W (32),
        .QDEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .pc_back_o     (pc_back_o),
        .mem_a_o       (mem_a_o),
        .mem_wr_o      (mem_wr_o),
        .mem_din_i     (mem_din_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    always #5 clk = ~clk;

    assign pc_i = pc_force_en ? pc_force : pc_back_o;

    // RAM contents: the first word is addi a0,x0,1 (00100513); elsewhere a
    // scrambled function of the address so every byte position differs.
    function automatic logic [7:0] ram_byte(input logic [31:0] addr);
        logic [7:0] r;
        case (addr)
            32'd0:   r = 8'h13;
            32'd1:   r = 8'h05;
            32'd2:   r = 8'h10;
            32'd3:   r = 8'h00;
            default: r = ((addr[7:0] * 8'd29) ^ addr[31:24] ^ 8'h5A);
        endcase
        return r;
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        return {ram_byte(pc + 32'd3), ram_byte(pc + 32'd2),
                ram_byte(pc + 32'd1), ram_byte(pc)};
    endfunction

    always @(posedge clk) mem_din_i <= ram_byte(mem_a_o);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        sb.push_back({exp_inst(pc), pc});
    endtask

    // Compare the DUT head against the oldest expected entry without taking it.
    task automatic check_head(input string tag);
        logic [63:0] e;
        e = sb[0];
        chk({tag, "_valid"}, 64'(inst_valid_o), 64'(1));
        chk({tag, "_inst"}, 64'(inst_o), 64'(e[63:32]));
        chk({tag, "_pc"}, 64'(inst_pc_o), 64'(e[31:0]));
    endtask

    // Compare the head, then accept it with ready for the coming edge.
    task automatic consume(input string tag);
        check_head(tag);
        void'(sb.pop_front());
        inst_ready_i = 1'b1;
    endtask

    initial begin
        rst         = 1'b1;
        pc_force_en = 1'b1;
        pc_force    = 32'h0;
        repeat (2) next_cycle();

        chk("rst_valid", 64'(inst_valid_o), 64'(0));
        chk("rst_inst", 64'(inst_o), 64'(0));
        chk("rst_inst_pc", 64'(inst_pc_o), 64'(0));
        chk("rst_pc_back", 64'(pc_back_o), 64'(0));
        chk("rst_mem_a", 64'(mem_a_o), 64'(0));
        chk("rst_mem_wr", 64'(mem_wr_o), 64'(0));

        // From here the PC register model follows pc_back_o (still 0).
        rst         = 1'b0;
        pc_force_en = 1'b0;
        expect_fetch(32'h0);
        expect_fetch(32'h4);

        for (int k = 0; k < 4; k++) begin
            next_cycle();
            chk("fetch0_addr", 64'(mem_a_o), 64'(k));
        end
        next_cycle();
        chk("latency_not_yet", 64'(inst_valid_o), 64'(0));
        next_cycle();
        chk("first_inst_const", 64'(inst_o), 64'(32'h0010_0513));
        check_head("first");
        chk("first_pc_back", 64'(pc_back_o), 64'(4));

        // Decode stalls: second word fills the queue and fetch goes idle.
        repeat (6) next_cycle();
        chk("full_pc_back", 64'(pc_back_o), 64'(8));
        chk("full_head_pc", 64'(inst_pc_o), 64'(0));
        chk("full_mem_a", 64'(mem_a_o), 64'(7));
        repeat (2) next_cycle();
        chk("idle_mem_a_hold", 64'(mem_a_o), 64'(7));
        chk("idle_pc_back", 64'(pc_back_o), 64'(8));

        expect_fetch(32'h8);
        consume("pop0");
        next_cycle();
        inst_ready_i = 1'b0;
        check_head("after_pop0");
        chk("resume_mem_a", 64'(mem_a_o), 64'(8));

        repeat (5) next_cycle();
        chk("refill_pc_back", 64'(pc_back_o), 64'(12));
        consume("pop4");
        next_cycle();
        inst_ready_i = 1'b0;
        check_head("after_pop4");
        chk("fetch12_b0", 64'(mem_a_o), 64'(12));

        // Redirect while addressing byte 2 of pc 12.
        repeat (2) next_cycle();
        chk("fetch12_b2", 64'(mem_a_o), 64'(14));
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        next_cycle();
        redirect_i = 1'b0;
        sb.delete();
        expect_fetch(32'h100);
        chk("redir_mem_a", 64'(mem_a_o), 64'(32'h100));
        chk("redir_valid", 64'(inst_valid_o), 64'(0));
        chk("redir_pc_back", 64'(pc_back_o), 64'(32'h100));
        repeat (4) next_cycle();
        chk("redir_latency", 64'(inst_valid_o), 64'(0));
        next_cycle();
        check_head("redir_first");

        // Redirect in B4 of pc 0x104 while decode pops pc 0x100.
        repeat (4) next_cycle();
        chk("b4_mem_a_hold", 64'(mem_a_o), 64'(32'h107));
        consume("pop100");
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        next_cycle();
        inst_ready_i = 1'b0;
        redirect_i   = 1'b0;
        sb.delete();
        expect_fetch(32'h200);
        chk("b4redir_valid", 64'(inst_valid_o), 64'(0));
        chk("b4redir_mem_a", 64'(mem_a_o), 64'(32'h200));
        chk("b4redir_pc_back", 64'(pc_back_o), 64'(32'h200));
        repeat (4) next_cycle();
        chk("b4redir_still_empty", 64'(inst_valid_o), 64'(0));
        next_cycle();
        check_head("b4redir_first");

        // Reset in B3 of pc 0x204 with one entry queued.
        repeat (3) next_cycle();
        chk("pre_rst_b3", 64'(mem_a_o), 64'(32'h207));
        rst = 1'b1;
        next_cycle();
        chk("midrst_valid", 64'(inst_valid_o), 64'(0));
        chk("midrst_inst", 64'(inst_o), 64'(0));
        chk("midrst_inst_pc", 64'(inst_pc_o), 64'(0));
        chk("midrst_pc_back", 64'(pc_back_o), 64'(0));
        chk("midrst_mem_a", 64'(mem_a_o), 64'(0));
        chk("midrst_mem_wr", 64'(mem_wr_o), 64'(0));

        // Address wrap at the top of memory.
        rst         = 1'b0;
        pc_force_en = 1'b1;
        pc_force    = 32'hFFFF_FFFC;
        sb.delete();
        expect_fetch(32'hFFFF_FFFC);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            chk("wrap_addr", 64'(mem_a_o), 64'(32'hFFFF_FFFC + 32'(k)));
        end
        next_cycle();
        chk("wrap_latency", 64'(inst_valid_o), 64'(0));
        next_cycle();
        check_head("wrap");
        chk("wrap_pc_back", 64'(pc_back_o), 64'(0));
        chk("wrap_next_addr", 64'(mem_a_o), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
